mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 38 +++
 rtl/mem_arb_grant.sv | 62 ++++++
 rtl/mem_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and helpers for the two-port memory arbiter:
//               FSM state encoding, requester identifiers, word-alignment
//               constant and the address legality check.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Requester identifiers (fetch port, data port)
    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_t;

    // Low address bits that must be zero for a word access
    localparam logic [1:0] C_WORD_ALIGN_MASK = 2'b11;

    // An address is illegal when misaligned or when the word would extend
    // past the end of the RAM (last legal word address is limit-4).
    function automatic logic addr_illegal(input logic [31:0] addr,
                                          input logic [31:0] limit);
        return ((addr[1:0] & C_WORD_ALIGN_MASK) != 2'b00) ||
               (addr > (limit - 32'd4));
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arb_grant.sv
// ============================================================================
// Module      : mem_arb_grant
// Description : Combinational grant selection between the fetch and data
//               requesters. With MEM_ARB_ROUND_ROBIN_EN defined, simultaneous
//               requests alternate using a last-granted pointer; otherwise the
//               data port has fixed priority and no pointer exists.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arb_grant
    import mem_arb_pkg::*;
(
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    grant_en_i,
    input  logic    fetch_req_i,
    input  logic    data_req_i,
    output logic    gnt_valid_o,
    output req_id_t gnt_id_o
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    req_id_t last_q;
    req_id_t last_d;

    // Round-robin select: on a tie, grant the port that did not win last time
    always_comb begin
        gnt_valid_o = grant_en_i && (fetch_req_i || data_req_i);
        if (fetch_req_i && data_req_i) begin
            gnt_id_o = (last_q == REQ_I) ? REQ_D : REQ_I;
        end else if (data_req_i) begin
            gnt_id_o = REQ_D;
        end else begin
            gnt_id_o = REQ_I;
        end
        last_d = gnt_valid_o ? gnt_id_o : last_q;
    end

    // Pointer register: remembers the most recent winner
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= REQ_I;
        end else begin
            last_q <= last_d;
        end
    end
`else
    // Clock and reset are only needed by the pointer register
    logic w_unused;
    assign w_unused = clk_i ^ rst_i;

    // Fixed priority select: the data port always wins a tie
    always_comb begin
        gnt_valid_o = grant_en_i && (fetch_req_i || data_req_i);
        gnt_id_o    = data_req_i ? REQ_D : REQ_I;
    end
`endif

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Two-port (instruction fetch / data) arbiter in front of a
//               single-port word RAM with registered read data. One
//               transaction in flight: IDLE -> ACCESS -> RESP, or IDLE -> RESP
//               for illegal addresses. Optional feature macro:
//               MEM_ARB_ROUND_ROBIN_EN (round-robin instead of data priority).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_LIMIT = 16
) (
    input  logic        clock,
    input  logic        reset,
    // instruction fetch port
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic        i_err,
    output logic [31:0] i_rdata,
    // data port
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic        d_err,
    output logic [31:0] d_rdata,
    // RAM side
    output logic        ram_write_enable,
    output logic [31:0] ram_address,
    output logic [31:0] ram_in,
    input  logic [31:0] ram_out,
    // status
    output logic        busy
);

    localparam logic [31:0] C_LIMIT = 32'(ADDR_LIMIT);

    state_t      state_q, state_d;
    req_id_t     gnt_q;
    logic        we_q;
    logic        err_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic        w_grant_en;
    logic        w_gnt_valid;
    req_id_t     w_gnt_id;
    logic [31:0] w_sel_addr;
    logic        w_sel_illegal;
    logic        w_resp;

    // Grants are only decided from requests seen while IDLE
    assign w_grant_en = (state_q == IDLE) && !reset;

    mem_arb_grant u_grant (
        .clk_i       (clock),
        .rst_i       (reset),
        .grant_en_i  (w_grant_en),
        .fetch_req_i (i_req),
        .data_req_i  (d_req),
        .gnt_valid_o (w_gnt_valid),
        .gnt_id_o    (w_gnt_id)
    );

    assign w_sel_addr    = (w_gnt_id == REQ_D) ? d_addr : i_addr;
    assign w_sel_illegal = addr_illegal(w_sel_addr, C_LIMIT);

    // Next-state logic; illegal addresses skip the RAM access entirely
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (w_gnt_valid) begin
                    state_d = w_sel_illegal ? RESP : ACCESS;
                end
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the winning request so the requester may change its inputs later
    always_ff @(posedge clock) begin
        if (reset) begin
            gnt_q   <= REQ_I;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
        end else if (w_gnt_valid) begin
            gnt_q   <= w_gnt_id;
            we_q    <= (w_gnt_id == REQ_D) ? d_we : 1'b0;
            err_q   <= w_sel_illegal;
            addr_q  <= w_sel_addr;
            wdata_q <= (w_gnt_id == REQ_D) ? d_wdata : 32'd0;
        end
    end

    // Output decode; reset masks every output in the same cycle so a write
    // in flight during ACCESS never reaches the RAM
    always_comb begin
        w_resp           = (state_q == RESP) && !reset;
        i_ack            = w_resp && (gnt_q == REQ_I);
        d_ack            = w_resp && (gnt_q == REQ_D);
        i_err            = i_ack && err_q;
        d_err            = d_ack && err_q;
        i_rdata          = (i_ack && !err_q) ? ram_out : 32'd0;
        d_rdata          = (d_ack && !err_q && !we_q) ? ram_out : 32'd0;
        ram_write_enable = (state_q == ACCESS) && we_q && !reset;
        ram_address      = reset ? 32'd0 : addr_q;
        ram_in           = reset ? 32'd0 : wdata_q;
        busy             = (state_q != IDLE) && !reset;
    end

endmodule

`default_nettype wire
